// File: rtl/demux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_pkg : shared constants and FSM encoding for demux1to4_stream
// Rev 1.0
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } demux_state_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_out_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux_out_reg : one-entry valid/ready output register (data + last)
// Rev 1.0
// ---------------------------------------------------------------------------
module demux_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_last;

  // A write is only issued when the slot is empty or draining, so it may
  // always overwrite; that is what gives the zero-bubble reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule : demux_out_reg
`default_nettype wire

// File: rtl/demux1to4_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// demux1to4_stream : registered 1-to-4 valid/ready packet demultiplexer
// Optional per-port beat counters on m_cnt when DEMUX_CNT_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_last,
  input  logic [SEL_W-1:0]      s_sel,
  output logic [NUM_OUT-1:0]    m_valid,
  input  logic [NUM_OUT-1:0]    m_ready,
  output logic [NUM_OUT*DW-1:0] m_data,
  output logic [NUM_OUT-1:0]    m_last
`ifdef DEMUX_CNT_EN
  ,
  output logic [NUM_OUT*CNT_W-1:0] m_cnt
`endif
);

  demux_state_t       r_state;
  demux_state_t       w_state_nxt;
  logic [SEL_W-1:0]   r_lock;
  logic [SEL_W-1:0]   w_dest;
  logic               w_accept;
  logic [NUM_OUT-1:0] w_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_accept && !s_last)
        r_lock <= s_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && !s_last) w_state_nxt = BUSY;
      BUSY:    if (w_accept && s_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // s_sel only steers the first beat; the rest of the packet follows r_lock.
  always_comb begin
    w_dest  = (r_state == BUSY) ? r_lock : s_sel;
    s_ready = !m_valid[w_dest] || m_ready[w_dest];
  end

  assign w_accept = s_valid && s_ready;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_port
    assign w_wr[i] = w_accept && (w_dest == SEL_W'(i));

    demux_out_reg #(.DW(DW)) u_out_reg (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr[i]),
      .i_data  (s_data),
      .i_last  (s_last),
      .i_ready (m_ready[i]),
      .o_valid (m_valid[i]),
      .o_data  (m_data[i*DW +: DW]),
      .o_last  (m_last[i])
    );
  end

`ifdef DEMUX_CNT_EN
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_cnt <= '0;
      else if (w_wr[i])
        r_cnt <= r_cnt + 1'b1;
    end

    assign m_cnt[i*CNT_W +: CNT_W] = r_cnt;
  end
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = |CNT_W;
`endif

endmodule : demux1to4_stream
`default_nettype wire

// File: tb/tb_demux1to4_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_demux1to4_stream : vector table plus per-port scoreboard queues
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_demux1to4_stream;

  localparam int DW    = 8;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [1:0]    s_sel;
  logic [3:0]    m_valid;
  logic [3:0]    m_ready;
  logic [4*DW-1:0] m_data;
  logic [3:0]    m_last;
`ifdef DEMUX_CNT_EN
  logic [4*CNT_W-1:0] m_cnt;
`endif

  demux1to4_stream #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_sel   (s_sel),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
`ifdef DEMUX_CNT_EN
    ,
    .m_cnt   (m_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: {last, data} per port, pushed on accept, popped on drain.
  logic [DW:0] sbq [4][$];
  logic        m_busy = 1'b0;
  logic [1:0]  m_lock = 2'd0;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) sbq[i].delete();
      m_busy = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i]) begin
          check($sformatf("port%0d_valid_has_beat", i), 32'(sbq[i].size() != 0), 32'd1);
          if (m_ready[i] && sbq[i].size() != 0) begin
            check($sformatf("port%0d_sb_beat", i), 32'({m_last[i], m_data[i*DW +: DW]}),
                  32'(sbq[i][0]));
            void'(sbq[i].pop_front());
          end
        end
      end
      if (s_valid && s_ready) begin
        logic [1:0] d;
        d = m_busy ? m_lock : s_sel;
        sbq[d].push_back({s_last, s_data});
        if (!m_busy && !s_last) begin
          m_busy = 1'b1;
          m_lock = s_sel;
        end else if (m_busy && s_last) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic [3:0] rdy;
    logic       exp_sr;
    logic [3:0] exp_mv;
    logic [1:0] exp_port;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [1:0] sel, logic [7:0] data, logic last,
                              logic [3:0] rdy, logic exp_sr, logic [3:0] exp_mv,
                              logic [1:0] exp_port, logic [7:0] exp_data, logic exp_last);
    vec_t r;
    r.v = v; r.sel = sel; r.data = data; r.last = last; r.rdy = rdy;
    r.exp_sr = exp_sr; r.exp_mv = exp_mv; r.exp_port = exp_port;
    r.exp_data = exp_data; r.exp_last = exp_last;
    return r;
  endfunction

  task automatic drive(logic v, logic [1:0] sel, logic [7:0] data, logic last, logic [3:0] rdy);
    s_valid = v; s_sel = sel; s_data = data; s_last = last; m_ready = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single beats, one per port, all ready
    vecs.push_back(mk(1, 2'd0, 8'hA0, 1, 4'hF, 1, 4'b0001, 2'd0, 8'hA0, 1));
    vecs.push_back(mk(1, 2'd1, 8'hA1, 1, 4'hF, 1, 4'b0010, 2'd1, 8'hA1, 1));
    vecs.push_back(mk(1, 2'd2, 8'hA2, 1, 4'hF, 1, 4'b0100, 2'd2, 8'hA2, 1));
    vecs.push_back(mk(1, 2'd3, 8'hA3, 1, 4'hF, 1, 4'b1000, 2'd3, 8'hA3, 1));
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 4'hF, 1, 4'b0000, 2'd0, 8'h00, 0));
    // Packet lock: sel toggles after the first beat
    vecs.push_back(mk(1, 2'd2, 8'h11, 0, 4'hF, 1, 4'b0100, 2'd2, 8'h11, 0));
    vecs.push_back(mk(1, 2'd0, 8'h22, 0, 4'hF, 1, 4'b0100, 2'd2, 8'h22, 0));
    vecs.push_back(mk(1, 2'd3, 8'h33, 1, 4'hF, 1, 4'b0100, 2'd2, 8'h33, 1));
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 4'hF, 1, 4'b0000, 2'd0, 8'h00, 0));
    // Backpressure on port 1, then zero-bubble reload
    vecs.push_back(mk(1, 2'd1, 8'h44, 1, 4'b1101, 1, 4'b0010, 2'd1, 8'h44, 1));
    vecs.push_back(mk(1, 2'd1, 8'h55, 1, 4'b1101, 0, 4'b0010, 2'd1, 8'h44, 1));
    vecs.push_back(mk(1, 2'd1, 8'h55, 1, 4'b1111, 1, 4'b0010, 2'd1, 8'h55, 1));
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 4'hF, 1, 4'b0000, 2'd0, 8'h00, 0));
    // Port 3 stalled while port 0 keeps flowing
    vecs.push_back(mk(1, 2'd3, 8'h66, 1, 4'b0111, 1, 4'b1000, 2'd3, 8'h66, 1));
    vecs.push_back(mk(1, 2'd0, 8'h70, 1, 4'b0111, 1, 4'b1001, 2'd0, 8'h70, 1));
    vecs.push_back(mk(1, 2'd0, 8'h71, 1, 4'b0111, 1, 4'b1001, 2'd0, 8'h71, 1));
    vecs.push_back(mk(1, 2'd3, 8'h77, 1, 4'b0111, 0, 4'b1000, 2'd3, 8'h66, 1));
    vecs.push_back(mk(0, 2'd0, 8'h00, 0, 4'hF, 1, 4'b0000, 2'd0, 8'h00, 0));

    rst = 1'b1;
    drive(0, 2'd0, 8'h00, 0, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("reset_m_valid", 32'(m_valid), 32'h0);
    check("reset_m_data", m_data, 32'h0);
    check("reset_m_last", 32'(m_last), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].v, vecs[k].sel, vecs[k].data, vecs[k].last, vecs[k].rdy);
      #1;
      check($sformatf("vec%0d_s_ready", k), 32'(s_ready), 32'(vecs[k].exp_sr));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_m_valid", k), 32'(m_valid), 32'(vecs[k].exp_mv));
      if (vecs[k].exp_mv[vecs[k].exp_port]) begin
        check($sformatf("vec%0d_m_data", k), 32'(m_data[vecs[k].exp_port*DW +: DW]),
              32'(vecs[k].exp_data));
        check($sformatf("vec%0d_m_last", k), 32'(m_last[vecs[k].exp_port]),
              32'(vecs[k].exp_last));
      end
    end

    // Reset mid-packet with port 2 locked and full
    drive(1, 2'd2, 8'h88, 0, 4'b1011);
    @(posedge clk);
    #1;
    check("midpkt_m_valid", 32'(m_valid), 32'b0100);
    drive(1, 2'd0, 8'h89, 0, 4'b1011);
    #1;
    check("midpkt_lock_s_ready", 32'(s_ready), 32'd0);
    #1;
    rst = 1'b1;
    s_valid = 1'b0;
    #1;
    check("async_reset_m_valid", 32'(m_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 2'd1, 8'h99, 1, 4'hF);
    @(posedge clk);
    #1;
    check("post_reset_m_valid", 32'(m_valid), 32'b0010);
    check("post_reset_m_data", 32'(m_data[1*DW +: DW]), 32'h99);
    s_valid = 1'b0;

`ifdef DEMUX_CNT_EN
    for (int k = 0; k < 16; k++) begin
      drive(1, 2'd1, 8'(k), 1, 4'hF);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("m_cnt_wrap", 32'(m_cnt), 32'h0010);
`endif

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("port%0d_sb_empty", i), 32'(sbq[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux1to4_stream
`default_nettype wire
